// File: rtl/arm_pipe_pkg.sv
// rtl/arm_pipe_pkg.sv - shared types and constants for the ARM-subset pipeline
//
// Purpose : FSM state encoding, register-index width and the default SRAM
//           wait limit shared by the hazard controller and its sub-module.
// Ports   : none (package).
package arm_pipe_pkg;

  localparam int REG_W            = 4;
  localparam int DEFAULT_MAX_WAIT = 15;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - read-after-write hazard term for the instruction in ID
//
// Purpose : Compares the decoded source registers against the EXE and MEM
//           destinations. With forwarding active only a load in EXE can
//           stall, because every other result is forwarded in time.
// Ports   : src1/src2, rn_used/two_src   - sources of the instruction in ID
//           exe_dest/mem_dest, *_wb_en   - producers in EXE and MEM
//           exe_mem_read                 - EXE holds a load
//           forward_en                   - forwarding unit active
//           hazard                       - ID must stall
module hazard_detect
  import arm_pipe_pkg::*;
(
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             rn_used,
  input  logic             two_src,
  input  logic [REG_W-1:0] exe_dest,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             exe_wb_en,
  input  logic             mem_wb_en,
  input  logic             exe_mem_read,
  input  logic             forward_en,
  output logic             hazard
);

  logic w_exe_match;
  logic w_mem_match;

  // R0 is an ordinary register here, so a destination of 0 matches too.
  assign w_exe_match = exe_wb_en &&
                       (((src1 == exe_dest) && rn_used) || ((src2 == exe_dest) && two_src));
  assign w_mem_match = mem_wb_en &&
                       (((src1 == mem_dest) && rn_used) || ((src2 == mem_dest) && two_src));

  assign hazard = forward_en ? (w_exe_match && exe_mem_read)
                             : (w_exe_match || w_mem_match);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - stall/flush/freeze sequencer beside the ID stage
//
// Purpose : Resolves RAW hazards with stalls and bubbles, flushes the front
//           end on taken branches, freezes the pipe while the SRAM stage
//           waits and faults after MAX_WAIT wait cycles. Keeps saturating
//           stall and flush counters.
// Ports   : clk, rst (sync, active-high)
//           src1..forward_en        - hazard inputs (see hazard_detect)
//           branch_taken            - EXE resolved a taken branch
//           mem_req, mem_ready      - SRAM access in MEM and its completion
//           cnt_clr                 - clear both counters
//           freeze_front, flush_front, flush_id, freeze_back - controls (comb)
//           mem_fault               - sticky SRAM timeout
//           stall_cycles, flush_count - saturating performance counters
module pipeline_hazard_controller
  import arm_pipe_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             rn_used,
  input  logic             two_src,
  input  logic [REG_W-1:0] exe_dest,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             exe_wb_en,
  input  logic             mem_wb_en,
  input  logic             exe_mem_read,
  input  logic             forward_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             cnt_clr,
  output logic             freeze_front,
  output logic             flush_front,
  output logic             flush_id,
  output logic             freeze_back,
  output logic             mem_fault,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_wait_cnt;
  logic [7:0]       w_wait_nxt;
  logic [7:0]       w_wait_inc;
  logic             r_mem_fault;
  logic             w_fault_set;
  logic             w_resolve;
  logic             w_hazard;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  hazard_detect u_hazard_detect (
    .src1         (src1),
    .src2         (src2),
    .rn_used      (rn_used),
    .two_src      (two_src),
    .exe_dest     (exe_dest),
    .mem_dest     (mem_dest),
    .exe_wb_en    (exe_wb_en),
    .mem_wb_en    (mem_wb_en),
    .exe_mem_read (exe_mem_read),
    .forward_en   (forward_en),
    .hazard       (w_hazard)
  );

  assign w_wait_inc = r_wait_cnt + 8'd1;

  always_comb begin
    freeze_front = 1'b0;
    flush_front  = 1'b0;
    flush_id     = 1'b0;
    freeze_back  = 1'b0;
    w_state_nxt  = r_state;
    w_wait_nxt   = r_wait_cnt;
    w_fault_set  = 1'b0;
    w_resolve    = 1'b0;

    if (!rst) begin
      case (r_state)
        RUN: begin
          if (mem_req && !mem_ready) begin
            freeze_front = 1'b1;
            freeze_back  = 1'b1;
            // This cycle is the first wait cycle; a limit of 1 is already spent.
            if (LP_MAX_WAIT <= 8'd1) begin
              w_state_nxt = FAULT;
              w_fault_set = 1'b1;
            end else begin
              w_state_nxt = MEM_WAIT;
              w_wait_nxt  = 8'd1;
            end
          end else begin
            w_resolve = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!mem_ready) begin
            freeze_front = 1'b1;
            freeze_back  = 1'b1;
            // wait_cnt counts completed wait cycles; fault once this one reaches the limit.
            if (w_wait_inc >= LP_MAX_WAIT) begin
              w_state_nxt = FAULT;
              w_fault_set = 1'b1;
            end else begin
              w_wait_nxt = w_wait_inc;
            end
          end else begin
            w_state_nxt = RUN;
            w_wait_nxt  = 8'd0;
            w_resolve   = 1'b1;
          end
        end
        FAULT: begin
          freeze_front = 1'b1;
          freeze_back  = 1'b1;
        end
        default: begin
          w_state_nxt = RUN;
          w_wait_nxt  = 8'd0;
        end
      endcase

      // Branch beats hazard: the stalled instruction is on the wrong path anyway.
      if (w_resolve) begin
        if (branch_taken) begin
          flush_front = 1'b1;
          flush_id    = 1'b1;
        end else if (w_hazard) begin
          freeze_front = 1'b1;
          flush_id     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= RUN;
      r_wait_cnt     <= 8'd0;
      r_mem_fault    <= 1'b0;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_fault_set) begin
        r_mem_fault <= 1'b1;
      end
      if (cnt_clr) begin
        r_stall_cycles <= '0;
      end else if (freeze_front && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (cnt_clr) begin
        r_flush_count <= '0;
      end else if (flush_front && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + CNT_W'(1);
      end
    end
  end

  assign mem_fault    = r_mem_fault;
  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Sequencing controller for the five-stage ARM-subset pipeline. Sits beside the ID stage and its pipeline register: it detects read-after-write hazards on the decoded source registers and resolves them with stalls and bubbles. It also flushes the front end on taken branches and freezes the whole pipe while the SRAM memory stage is waiting. It keeps saturating stall and flush counters for performance measurement.

## Interface
- CNT_W, 16, width of the performance counters
- MAX_WAIT, 15, maximum SRAM wait cycles before a fault is raised; legal range 1..255
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- src1  in  4  Rn field of the instruction in ID
- src2  in  4  Rm field, or Rd for stores
- rn_used  in  1  instruction in ID reads src1
- two_src  in  1  instruction in ID reads src2
- exe_dest, mem_dest  in  4  destination register of the EXE and MEM stages
- exe_wb_en, mem_wb_en  in  1  EXE and MEM stages write back
- exe_mem_read  in  1  EXE stage holds a load
- forward_en  in  1  forwarding unit active
- branch_taken  in  1  EXE resolved a taken branch
- mem_req  in  1  MEM stage holds a load or store
- mem_ready  in  1  SRAM transaction complete this cycle
- cnt_clr  in  1  synchronous clear of both counters
- freeze_front  out  1  hold the PC and the IF/ID register
- flush_front  out  1  clear the IF/ID register
- flush_id  out  1  load a bubble into the ID/EXE register
- freeze_back  out  1  hold the ID/EXE, EXE/MEM and MEM/WB registers
- mem_fault  out  1  sticky; SRAM timeout occurred
- stall_cycles  out  CNT_W  cycles with freeze_front=1, saturating
- flush_count  out  CNT_W  taken-branch flushes, saturating

## Operation
- States: RUN, MEM_WAIT, FAULT.
- Hazard term:
  - A match is `(src1 && rn_used) || (src2 && two_src)` against a destination.
  - With forward_en=0: hazard = match against exe_dest with exe_wb_en, or match against mem_dest with mem_wb_en.
  - With forward_en=1: hazard = match against exe_dest with exe_wb_en and exe_mem_read (load-use only).
- Output priority, evaluated in RUN, and in MEM_WAIT during the cycle mem_ready=1:
  1. mem_req=1 and mem_ready=0: freeze_front=1 and freeze_back=1. Next state MEM_WAIT, wait_cnt←1.
  2. Otherwise, branch_taken=1: flush_front=1 and flush_id=1. The hazard term is ignored.
  3. Otherwise, hazard=1: freeze_front=1 and flush_id=1.
  4. Otherwise: all control outputs 0.
- MEM_WAIT with mem_ready=0:
  - freeze_front=1, freeze_back=1; branch and hazard are ignored.
  - wait_cnt increments.
  - When wait_cnt=MAX_WAIT and the cycle ends without ready: next state FAULT and mem_fault←1.
- MEM_WAIT with mem_ready=1: next state RUN, and outputs follow the priority list with rule 1 false.
- FAULT: freeze_front=1 and freeze_back=1 permanently. Only rst exits FAULT.
- Counters:
  - stall_cycles increments on every cycle with freeze_front=1.
  - flush_count increments on every cycle rule 2 fires.
  - Both saturate at all-ones.
  - cnt_clr overrides increments (counter becomes 0 that edge).

## Timing
- Control outputs are combinational from the current state and inputs, with 0 cycles latency. The state, wait_cnt, counters and mem_fault are registered.
- Reset:
  - While rst=1, all control outputs are 0.
  - On the edge: state=RUN, wait_cnt=0, mem_fault=0, stall_cycles=0, flush_count=0.
  - rst during MEM_WAIT or FAULT returns to RUN on that edge.
- A load-use stall lasts exactly 1 cycle with forwarding. Without forwarding it lasts up to 2 cycles, until the producer leaves MEM.
- An SRAM access with N wait cycles (mem_ready on cycle N+1) freezes the pipe for exactly N cycles.
- A simultaneous branch and hazard produces a flush only; the stall counter does not increment.
- Register R0 is not special: a dest of 0 still matches.

## Structure
- Shared package `arm_pipe_pkg` holds:
  - the state enum (RUN=2'd0, MEM_WAIT=2'd1, FAULT=2'd2);
  - the 4-bit register-index width;
  - the default MAX_WAIT.
- One natural combinational sub-module, `hazard_detect`, computes the hazard term from the source, destination and forward_en inputs.
- The FSM and counters live in the top module.

## Test plan
- src1=3, rn_used=1, exe_dest=3, exe_wb_en=1, forward_en=0 -> freeze_front=1 and flush_id=1 that cycle. When the producer moves to MEM, the stall holds one more cycle, then clears.
- Same hazard with forward_en=1 and exe_mem_read=0 -> no stall. With exe_mem_read=1 -> exactly 1 stall cycle, and stall_cycles=1.
- branch_taken=1 together with a hazard -> flush_front=1, flush_id=1, freeze_front=0; flush_count=1.
- mem_req=1 with mem_ready low for 4 cycles -> freeze_front and freeze_back high for 4 cycles. On the 5th cycle they drop, state returns to RUN, and stall_cycles=4.
- MAX_WAIT=3 and mem_ready held low -> FAULT after the 3rd wait cycle, mem_fault=1, freezes persist. A 1-cycle rst clears everything to the reset values.
- 2^CNT_W+5 forced stall cycles -> stall_cycles holds at all-ones. cnt_clr -> 0 on the next edge.
